conv_line_feeder: RTL and testbench
===================================

Name: conv_line_feeder

Overview:
- Producer side of the convolve window interface. Buffers an incoming raster pixel stream into three row banks.
- Presents one 3-pixel column per cycle on out_l1/out_l2/out_l3, which drive convolve in_l1/in_l2/in_l3.
- Advances one column on each convolve shift_buffer request.
- On convolve done, loads `stride` new rows and rotates the banks so out_l1 always carries the oldest (top) row.

Parameters:
- BIT_DEPTH, 8, pixel width.
- IMG_WIDTH, 16, pixels per row (≥2).
- IMG_HEIGHT, 16, rows per frame (≥3).
- COL_W, $clog2(IMG_WIDTH), column index width.
- ROW_W, $clog2(IMG_HEIGHT+1), row counter width.

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, begin a frame; honoured only in IDLE.
- stride, input, 2, rows advanced per window step; sampled on start; value 0 is treated as 1.
- pix_in, input, BIT_DEPTH, stream pixel, raster order.
- pix_valid, input, 1, pix_in is valid.
- pix_ready, output, 1, feeder accepts pix_in this cycle.
- shift_buffer, input, 1, from convolve: advance one column.
- conv_done, input, 1, from convolve done: window row complete.
- out_l1, output, BIT_DEPTH, top-row pixel at rd_col.
- out_l2, output, BIT_DEPTH, middle-row pixel at rd_col.
- out_l3, output, BIT_DEPTH, bottom-row pixel at rd_col.
- window_valid, output, 1, three rows resident; outputs meaningful.
- row_end, output, 1, rd_col == IMG_WIDTH-1.
- frame_done, output, 1, one-cycle pulse at end of frame.

Behaviour:

Reset:
- Asynchronous on rst=1.
- State goes to IDLE.
- pix_ready, window_valid, row_end and frame_done go to 0.
- rd_col, wr_col, rows_loaded, need and top_ptr go to 0.
- out_l* read 0 while window_valid=0 (gated).
- Bank contents are not cleared.
- Reset asserted mid-FILL or mid-SERVE aborts the frame; no frame_done is issued.

State IDLE:
- pix_ready=0.
- On start: latch stride (0→1), set need=3, go to FILL.

State FILL:
- pix_ready=1.
- Handshake condition: pix_valid & pix_ready.
- On each handshake: write pix_in to bank wr_bank at wr_col, then wr_col++.
- On the handshake at wr_col==IMG_WIDTH-1:
  - wr_col←0, rows_loaded++, need--.
  - wr_bank←(wr_bank+1) mod 3.
- When need reaches 0: go to SERVE with rd_col=0.
  - window_valid=1 in the cycle after the last handshake.
  - out_l* show column 0 in that same cycle.
- Gaps in pix_valid stall FILL without penalty.
- shift_buffer and conv_done are ignored in FILL.

State SERVE:
- pix_ready=0 and window_valid=1.
- Output mapping (combinational reads):
  - out_l1 = bank[top_ptr][rd_col]
  - out_l2 = bank[(top_ptr+1) mod 3][rd_col]
  - out_l3 = bank[(top_ptr+2) mod 3][rd_col]
- shift_buffer=1: rd_col increments at the clock edge; new values appear the next cycle.
  - At rd_col==IMG_WIDTH-1 the shift is ignored; rd_col saturates and row_end stays 1.
- conv_done=1 takes priority over a simultaneous shift_buffer (the shift is dropped):
  - If rows_loaded+stride > IMG_HEIGHT: go to DONE.
  - Otherwise: top_ptr←(top_ptr+stride) mod 3, need←stride, window_valid←0, rd_col←0, go to FILL.
  - The new rows are written into the banks being vacated, starting at wr_bank, which equals the old top_ptr.
- Stride 3 replaces all three rows.

State DONE:
- frame_done=1 for one cycle, window_valid=0, then IDLE.

General rules:
- start outside IDLE is ignored.
- Pixel data is passed through unmodified; no arithmetic on pixel values.
- Counter widths must not wrap for legal parameters.

Decomposition:
- Package conv_feeder_pkg holds:
  - the state encoding: IDLE=0, FILL=1, SERVE=2, DONE=3;
  - the NUM_ROWS=3 constant;
  - a mod-3 pointer increment function.
- Sub-module line_bank: IMG_WIDTH×BIT_DEPTH register row with one synchronous write port and one asynchronous read port. It is instantiated three times.
- The top level holds the FSM, the counters and the bank-rotation muxing.

Test Plan:
All scenarios use IMG_WIDTH=4 and IMG_HEIGHT=5, with pixel value = row*16+col.
1. Reset: rst high mid-stream → all outputs 0 immediately (asynchronous); state IDLE; pix_ready=0.
2. start, stride=1, 12 pixels streamed → window_valid rises 1 cycle after 12th handshake with out=(0,16,32); 3 shifts → (3,19,35), row_end=1; 4th shift leaves (3,19,35).
3. From scenario 2, conv_done → FILL, 4 pixels of row 3 → out=(16,32,48) at col 0; top_ptr=1.
4. stride=2: first window (0,16,32); conv_done → accept 8 pixels → (32,48,64); conv_done again (5+2>5) → frame_done single pulse, IDLE, pix_ready=0.
5. shift_buffer and conv_done same cycle in SERVE → shift dropped, FILL entered, rd_col=0; pix_valid toggling 1/0 during FILL → exactly one write per handshake, same final window.
6. start asserted during SERVE → ignored; rst during FILL after 6 pixels, then a new start → full 12-pixel refill required before window_valid.

Source files
------------

// File: rtl/conv_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_feeder_pkg
// Purpose  : Shared types and helpers for the convolve line feeder.
//            State encoding, row-bank count and mod-3 pointer arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
package conv_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        SERVE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NUM_ROWS = 3;

    // Next bank index, wrapping 2 -> 0.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // (p + n) mod 3 for n in 0..3.
    function automatic logic [1:0] ptr_add(input logic [1:0] p, input logic [1:0] n);
        logic [1:0] r;
        r = p;
        for (int i = 0; i < 3; i++) begin
            if (2'(i) < n) begin
                r = ptr_inc(r);
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_line_feeder_bank.sv
`default_nettype none
// ============================================================================
// Module   : line_bank
// Purpose  : One image row of pixel storage.
//            Synchronous write port, asynchronous (combinational) read port.
// Ports    : clk      - clock
//            wr_en    - write strobe
//            wr_col   - write column
//            wr_data  - pixel to store
//            rd_col   - read column
//            rd_data  - pixel at rd_col
// Revision : 1.0 - initial release
// ============================================================================
module line_bank #(
    parameter int BIT_DEPTH = 8,
    parameter int IMG_WIDTH = 16,
    parameter int COL_W     = $clog2(IMG_WIDTH)
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [COL_W-1:0]     wr_col,
    input  logic [BIT_DEPTH-1:0] wr_data,
    input  logic [COL_W-1:0]     rd_col,
    output logic [BIT_DEPTH-1:0] rd_data
);

    // Contents are deliberately not reset; a frame always refills before use.
    logic [BIT_DEPTH-1:0] r_mem [IMG_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_col] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_col];

endmodule
`default_nettype wire

// File: rtl/conv_line_feeder.sv
`default_nettype none
// ============================================================================
// Module   : conv_line_feeder
// Purpose  : Buffers a raster pixel stream into three rotating row banks and
//            presents one 3-pixel column per cycle to the convolve engine.
// Ports    : clk, rst            - clock, async active-high reset
//            start, stride       - begin frame / rows per window step
//            pix_in, pix_valid,
//            pix_ready           - input pixel stream handshake
//            shift_buffer        - advance one column
//            conv_done           - window row complete, load next rows
//            out_l1..out_l3      - top/middle/bottom pixel of current column
//            window_valid        - three rows resident
//            row_end             - read column is the last column
//            frame_done          - one-cycle end-of-frame pulse
// Revision : 1.0 - initial release
// ============================================================================
module conv_line_feeder
    import conv_feeder_pkg::*;
#(
    parameter int BIT_DEPTH  = 8,
    parameter int IMG_WIDTH  = 16,
    parameter int IMG_HEIGHT = 16,
    parameter int COL_W      = $clog2(IMG_WIDTH),
    parameter int ROW_W      = $clog2(IMG_HEIGHT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           stride,
    input  logic [BIT_DEPTH-1:0] pix_in,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    input  logic                 shift_buffer,
    input  logic                 conv_done,
    output logic [BIT_DEPTH-1:0] out_l1,
    output logic [BIT_DEPTH-1:0] out_l2,
    output logic [BIT_DEPTH-1:0] out_l3,
    output logic                 window_valid,
    output logic                 row_end,
    output logic                 frame_done
);

    localparam logic [COL_W-1:0] c_last_col = COL_W'(IMG_WIDTH - 1);

    state_t               r_state;
    state_t               w_next_state;
    logic [1:0]           r_stride;
    logic [1:0]           r_need;
    logic [1:0]           r_wr_bank;
    logic [1:0]           r_top_ptr;
    logic [ROW_W-1:0]     r_rows_loaded;
    logic [COL_W-1:0]     r_wr_col;
    logic [COL_W-1:0]     r_rd_col;

    logic                 w_hs;
    logic                 w_row_last;
    logic                 w_fill_done;
    logic [ROW_W+1:0]     w_rows_next;
    logic                 w_exhausted;
    logic [NUM_ROWS-1:0]  w_we;
    logic [BIT_DEPTH-1:0] w_rd [NUM_ROWS];

    assign w_hs        = (r_state == FILL) && pix_valid;
    assign w_row_last  = w_hs && (r_wr_col == c_last_col);
    assign w_fill_done = w_row_last && (r_need == 2'd1);
    // Frame ends when the next step would need rows beyond the image.
    assign w_rows_next = {2'b00, r_rows_loaded} + {{ROW_W{1'b0}}, r_stride};
    assign w_exhausted = w_rows_next > (ROW_W + 2)'(IMG_HEIGHT);
    assign row_end     = (r_rd_col == c_last_col);

    // ------------------------------------------------------------------
    // Row banks
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_ROWS; k++) begin : g_bank
        assign w_we[k] = w_hs && (r_wr_bank == 2'(k));

        line_bank #(
            .BIT_DEPTH (BIT_DEPTH),
            .IMG_WIDTH (IMG_WIDTH),
            .COL_W     (COL_W)
        ) u_bank (
            .clk     (clk),
            .wr_en   (w_we[k]),
            .wr_col  (r_wr_col),
            .wr_data (pix_in),
            .rd_col  (r_rd_col),
            .rd_data (w_rd[k])
        );
    end

    // Rotation: top_ptr names the bank holding the oldest resident row.
    always_comb begin
        out_l1 = '0;
        out_l2 = '0;
        out_l3 = '0;
        if (r_state == SERVE) begin
            case (r_top_ptr)
                2'd0: begin
                    out_l1 = w_rd[0];
                    out_l2 = w_rd[1];
                    out_l3 = w_rd[2];
                end
                2'd1: begin
                    out_l1 = w_rd[1];
                    out_l2 = w_rd[2];
                    out_l3 = w_rd[0];
                end
                default: begin
                    out_l1 = w_rd[2];
                    out_l2 = w_rd[0];
                    out_l3 = w_rd[1];
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        pix_ready    = 1'b0;
        window_valid = 1'b0;
        frame_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = FILL;
                end
            end
            FILL: begin
                pix_ready = 1'b1;
                if (w_fill_done) begin
                    w_next_state = SERVE;
                end
            end
            SERVE: begin
                window_valid = 1'b1;
                if (conv_done) begin
                    w_next_state = w_exhausted ? DONE : FILL;
                end
            end
            DONE: begin
                frame_done   = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Counters and pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stride      <= 2'd1;
            r_need        <= 2'd0;
            r_wr_bank     <= 2'd0;
            r_top_ptr     <= 2'd0;
            r_rows_loaded <= '0;
            r_wr_col      <= '0;
            r_rd_col      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_stride      <= (stride == 2'd0) ? 2'd1 : stride;
                        r_need        <= 2'd3;
                        r_wr_bank     <= 2'd0;
                        r_top_ptr     <= 2'd0;
                        r_rows_loaded <= '0;
                        r_wr_col      <= '0;
                        r_rd_col      <= '0;
                    end
                end
                FILL: begin
                    if (w_row_last) begin
                        r_wr_col      <= '0;
                        r_rows_loaded <= r_rows_loaded + ROW_W'(1);
                        r_need        <= r_need - 2'd1;
                        r_wr_bank     <= ptr_inc(r_wr_bank);
                    end else if (w_hs) begin
                        r_wr_col <= r_wr_col + COL_W'(1);
                    end
                end
                SERVE: begin
                    // conv_done wins over a coincident shift.
                    if (conv_done) begin
                        r_rd_col <= '0;
                        if (!w_exhausted) begin
                            r_top_ptr <= ptr_add(r_top_ptr, r_stride);
                            r_need    <= r_stride;
                        end
                    end else if (shift_buffer && (r_rd_col != c_last_col)) begin
                        r_rd_col <= r_rd_col + COL_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_line_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_line_feeder
// Purpose  : Randomized self-checking bench for conv_line_feeder. A row-level
//            image model predicts each presented column; a monitor pops and
//            compares expected windows and frame_done pulses.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_conv_line_feeder;

    localparam int BD = 8;
    localparam int W  = 4;
    localparam int H  = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    stride = 2'd0;
    logic [BD-1:0] pix_in = '0;
    logic          pix_valid = 1'b0;
    logic          shift_buffer = 1'b0;
    logic          conv_done = 1'b0;
    logic          pix_ready;
    logic [BD-1:0] out_l1;
    logic [BD-1:0] out_l2;
    logic [BD-1:0] out_l3;
    logic          window_valid;
    logic          row_end;
    logic          frame_done;

    conv_line_feeder #(
        .BIT_DEPTH  (BD),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stride       (stride),
        .pix_in       (pix_in),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .shift_buffer (shift_buffer),
        .conv_done    (conv_done),
        .out_l1       (out_l1),
        .out_l2       (out_l2),
        .out_l3       (out_l3),
        .window_valid (window_valid),
        .row_end      (row_end),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [24:0]   win_q[$];
    int            done_q[$];
    logic [BD-1:0] img [H][W];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(pix_ready), 32'd0);
        chk({tag, "_wv"}, 32'(window_valid), 32'd0);
        chk({tag, "_fd"}, 32'(frame_done), 32'd0);
        chk({tag, "_re"}, 32'(row_end), 32'd0);
        chk({tag, "_outs"}, 32'({out_l1, out_l2, out_l3}), 32'd0);
    endtask

    // Monitor: every presented window is compared with the oldest prediction.
    always @(negedge clk) begin
        logic [24:0] e;
        if (window_valid) begin
            if (win_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL window_unexpected actual=%0h required=none", {out_l1, out_l2, out_l3, row_end});
            end else begin
                e = win_q.pop_front();
                chk("window", 32'({out_l1, out_l2, out_l3, row_end}), 32'(e));
            end
        end
        if (frame_done) begin
            if (done_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL frame_done_unexpected actual=1 required=0");
            end else begin
                void'(done_q.pop_front());
                checks++;
            end
        end
    end

    // Streams rows first..first+cnt-1 with random gaps and ignored controls.
    // abort6 asserts reset after six handshakes.
    task automatic fill_rows(input int first, input int cnt, input bit abort6, output bit aborted);
        int n;
        n = 0;
        aborted = 1'b0;
        while (n < cnt * W) begin
            chk("fill_ready", 32'(pix_ready), 32'd1);
            chk("fill_wv", 32'(window_valid), 32'd0);
            if (abort6 && n == 6) begin
                pix_valid    = 1'b0;
                shift_buffer = 1'b0;
                conv_done    = 1'b0;
                #6;
                rst = 1'b1;
                #1;
                chk_reset_outputs("rst_fill");
                tick();
                rst = 1'b0;
                aborted = 1'b1;
                return;
            end
            pix_valid    = ($urandom_range(0, 3) != 0);
            pix_in       = pix_valid ? img[first + n / W][n % W] : BD'($urandom);
            shift_buffer = $urandom_range(0, 1) == 1;
            conv_done    = $urandom_range(0, 3) == 0;
            if (pix_valid) n++;
            tick();
        end
        pix_valid    = 1'b0;
        shift_buffer = 1'b0;
        conv_done    = 1'b0;
    endtask

    // abort_mode: 0 none, 1 reset mid-FILL, 2 reset mid-SERVE.
    task automatic run_frame(input logic [1:0] s_in, input int abort_mode, input bit ramp);
        int  s;
        int  top;
        int  loaded;
        int  col;
        int  steps;
        bit  ab;
        bit  fin;
        s      = (s_in == 2'd0) ? 1 : int'(s_in);
        top    = 0;
        fin    = 1'b0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = ramp ? BD'(r * 16 + c) : BD'($urandom);

        chk("idle_ready", 32'(pix_ready), 32'd0);
        start  = 1'b1;
        stride = s_in;
        tick();
        start  = 1'b0;
        fill_rows(0, 3, abort_mode == 1, ab);
        if (ab) return;
        loaded = 3;

        while (!fin) begin
            col   = 0;
            steps = $urandom_range(0, W + 2);
            for (int k = 0; k <= steps; k++) begin
                chk("serve_wv", 32'(window_valid), 32'd1);
                win_q.push_back({img[top][col], img[top + 1][col], img[top + 2][col], col == W - 1});
                if (abort_mode == 2 && k == 1) begin
                    #6;
                    rst = 1'b1;
                    #1;
                    chk_reset_outputs("rst_serve");
                    tick();
                    rst = 1'b0;
                    return;
                end
                if (k == steps) begin
                    conv_done    = 1'b1;
                    shift_buffer = $urandom_range(0, 1) == 1;
                end else begin
                    shift_buffer = $urandom_range(0, 3) != 0;
                end
                // start (with a different stride) must be ignored here
                start  = $urandom_range(0, 5) == 0;
                stride = 2'($urandom);
                tick();
                if (!conv_done && shift_buffer && col < W - 1) col++;
            end
            conv_done    = 1'b0;
            shift_buffer = 1'b0;
            start        = 1'b0;
            if (loaded + s > H) begin
                chk("done_wv", 32'(window_valid), 32'd0);
                done_q.push_back(1);
                tick();
                chk("post_done_ready", 32'(pix_ready), 32'd0);
                chk("post_done_fd", 32'(frame_done), 32'd0);
                fin = 1'b1;
            end else begin
                top = top + s;
                fill_rows(loaded, s, 1'b0, ab);
                loaded = loaded + s;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();
        run_frame(2'd1, 0, 1'b1);
        run_frame(2'd2, 0, 1'b1);
        run_frame(2'd0, 0, 1'b0);
        run_frame(2'd3, 0, 1'b0);
        run_frame(2'd1, 2, 1'b0);
        run_frame(2'd1, 1, 1'b1);
        run_frame(2'd1, 0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            run_frame(2'($urandom), 0, 1'b0);
        end
        repeat (3) tick();
        chk("win_q_drained", 32'(win_q.size()), 32'd0);
        chk("done_q_drained", 32'(done_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
